// File: rtl/gpio_apb_master.sv
// ============================================================================
// gpio_apb_master : single-outstanding APB requester with wait-state timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module gpio_apb_master #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic [7:0]        err_cnt,
   input  logic              err_cnt_clr,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   localparam logic       TO_EN     = (TIMEOUT != 0);
   localparam logic [7:0] WAIT_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic       accept;
   logic       done_ok;
   logic       abort;
   logic       err_inc;

   assign cmd_ready = (state == IDLE);
   assign PSEL      = (state == SETUP) || (state == ACCESS);
   assign PENABLE   = (state == ACCESS);
   assign rsp_valid = (state == RESP);

   assign accept  = cmd_valid & cmd_ready;
   assign done_ok = (state == ACCESS) & PREADY;
   assign abort   = (state == ACCESS) & ~PREADY & TO_EN & (wait_cnt == WAIT_LAST);
   assign err_inc = (done_ok & PSLVERR) | abort;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid)         state_nxt = SETUP;
         SETUP:                          state_nxt = ACCESS;
         ACCESS:  if (PREADY || abort)   state_nxt = RESP;
         RESP:    if (rsp_ready)         state_nxt = IDLE;
         default:                        state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         wait_cnt    <= 8'd0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         err_cnt     <= 8'd0;
      end else begin
         if (accept) begin
            PWRITE   <= cmd_write;
            PADDR    <= cmd_addr;
            PWDATA   <= cmd_wdata;
            wait_cnt <= 8'd0;
         end else if ((state == ACCESS) && !PREADY && !abort && (wait_cnt != 8'hFF)) begin
            // saturating so a disabled timeout cannot wrap the counter
            wait_cnt <= wait_cnt + 8'd1;
         end

         if (done_ok) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
         end else if (abort) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
         end

         if (err_cnt_clr)                       err_cnt <= {7'd0, err_inc};
         else if (err_inc && err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_gpio_apb_master.sv
// ============================================================================
// tb_gpio_apb_master : randomized transaction-level check of gpio_apb_master
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gpio_apb_master;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [5:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [7:0]  err_cnt;
   logic        err_cnt_clr;
   logic        psel, penable, pwrite;
   logic [5:0]  paddr;
   logic [31:0] pwdata, prdata;
   logic        pready, pslverr;

   gpio_apb_master #(.ADDR_W(6), .DATA_W(32), .TIMEOUT(T)) dut (
      .PCLK(clk), .PRESETn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr),
      .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
      .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // expected outputs, maintained by the transaction model below
   bit          chk_en = 0;
   bit          exp_cmd_ready, exp_psel, exp_pen, exp_pwrite, exp_rsp_valid;
   bit          exp_err, exp_to, rsp_known;
   logic [5:0]  exp_paddr;
   logic [31:0] exp_pwdata, exp_rdata;
   int          exp_errcnt;
   logic [31:0] mem [64];
   bit          hold_cmd_valid = 0;

   // observations used only by the literal checks
   int          obs_acc;
   logic [31:0] obs_rdata;
   logic        obs_err, obs_to;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_cmd_ready});
         chk("psel",      {31'd0, psel},      {31'd0, exp_psel});
         chk("penable",   {31'd0, penable},   {31'd0, exp_pen});
         chk("pwrite",    {31'd0, pwrite},    {31'd0, exp_pwrite});
         chk("paddr",     {26'd0, paddr},     {26'd0, exp_paddr});
         chk("pwdata",    pwdata,             exp_pwdata);
         chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rsp_valid});
         chk("err_cnt",   {24'd0, err_cnt},   exp_errcnt);
         if (exp_rsp_valid || rsp_known) begin
            chk("rsp_rdata",   rsp_rdata,            exp_rdata);
            chk("rsp_err",     {31'd0, rsp_err},     {31'd0, exp_err});
            chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, exp_to});
         end
      end
      if (psel === 1'b1 && penable === 1'b1) obs_acc++;
      if (rsp_valid === 1'b1) begin
         obs_rdata = rsp_rdata;
         obs_err   = rsp_err;
         obs_to    = rsp_timeout;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_reset_exp();
      exp_cmd_ready = 1; exp_psel = 0; exp_pen = 0; exp_pwrite = 0;
      exp_paddr = '0; exp_pwdata = '0; exp_rsp_valid = 0;
      exp_rdata = '0; exp_err = 0; exp_to = 0; exp_errcnt = 0; rsp_known = 1;
   endtask

   task automatic do_reset();
      rstn = 0; cmd_valid = 0;
      tick();
      set_reset_exp();
      chk_en = 1;
      rstn = 1;
   endtask

   task automatic junk_cmd();
      cmd_valid = hold_cmd_valid ? 1'b1 : 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = 6'($urandom);
      cmd_wdata = $urandom;
   endtask

   // One transfer: w = PREADY-low cycles requested, serr = PSLVERR on completion,
   // rdly = rsp_ready-low cycles, clr = err_cnt_clr on the RESP-entry edge.
   task automatic xfer(input bit wr, input logic [5:0] a, input logic [31:0] wd,
                       input int w, input bit serr, input int rdly, input bit clr);
      int  n_acc;
      bit  timed, inc;
      cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
      pready = 1'($urandom_range(0, 1)); prdata = $urandom;
      tick();
      junk_cmd();
      exp_cmd_ready = 0; exp_psel = 1; exp_pen = 0;
      exp_pwrite = wr; exp_paddr = a; exp_pwdata = wd;
      tick();
      exp_pen = 1;
      timed = (T != 0) && (w >= T);
      n_acc = timed ? T : w + 1;
      for (int i = 0; i < n_acc; i++) begin
         pready      = (!timed && i == w);
         prdata      = pready ? mem[a] : $urandom;
         pslverr     = pready ? serr : 1'($urandom_range(0, 1));
         err_cnt_clr = clr && (i == n_acc - 1);
         junk_cmd();
         tick();
      end
      pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1));
      prdata = $urandom; err_cnt_clr = 0;
      exp_psel = 0; exp_pen = 0; exp_rsp_valid = 1; rsp_known = 0;
      exp_rdata = (timed || wr) ? 32'd0 : mem[a];
      exp_err = timed || serr;
      exp_to  = timed;
      inc = exp_err;
      if (clr)                          exp_errcnt = inc ? 1 : 0;
      else if (inc && exp_errcnt < 255) exp_errcnt++;
      if (wr && !exp_err) mem[a] = wd;
      rsp_ready = 0;
      for (int j = 0; j < rdly; j++) begin
         junk_cmd();
         tick();
      end
      rsp_ready = 1;
      tick();
      rsp_ready = 0; cmd_valid = 0;
      exp_rsp_valid = 0; exp_cmd_ready = 1;
   endtask

   task automatic clear_cnt();
      err_cnt_clr = 1;
      tick();
      err_cnt_clr = 0;
      exp_errcnt = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      rstn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 0; err_cnt_clr = 0; prdata = '0; pready = 0; pslverr = 0;
      tick();
      do_reset();
      tick();

      // directed write then waited read-back
      obs_acc = 0;
      xfer(1, 6'h10, 32'h0000_00FF, 0, 0, 0, 0);
      chk("lit_wr_access_cycles", obs_acc, 1);
      chk("lit_wr_rdata", obs_rdata, 32'h0);
      obs_acc = 0;
      xfer(0, 6'h10, 32'h0, 3, 0, 0, 0);
      chk("lit_rd_access_cycles", obs_acc, 4);
      chk("lit_rd_rdata", obs_rdata, 32'h0000_00FF);
      chk("lit_rd_err", {31'd0, obs_err}, 32'd0);

      // timeout
      obs_acc = 0;
      xfer(0, 6'h10, 32'h0, 20, 0, 1, 0);
      chk("lit_to_access_cycles", obs_acc, 4);
      chk("lit_to_flags", {30'd0, obs_err, obs_to}, 32'd3);
      chk("lit_to_rdata", obs_rdata, 32'h0);
      chk("lit_to_err_cnt", {24'd0, err_cnt}, 32'd1);

      // slave error on a write, then saturation
      xfer(1, 6'h11, 32'hDEAD_BEEF, 1, 1, 0, 0);
      chk("lit_slverr_to", {31'd0, obs_to}, 32'd0);
      chk("lit_slverr_cnt", {24'd0, err_cnt}, 32'd2);
      for (int k = 0; k < 256; k++)
         xfer(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 2), 1, 0, 0);
      chk("lit_sat_cnt", {24'd0, err_cnt}, 32'd255);
      xfer(1, 6'h12, 32'h1, 0, 1, 0, 1);
      chk("lit_clr_with_err", {24'd0, err_cnt}, 32'd1);

      // response back-pressure with a pending command
      hold_cmd_valid = 1;
      xfer(0, 6'h10, 32'h0, 0, 0, 5, 0);
      hold_cmd_valid = 0;
      tick();

      // reset in the middle of ACCESS
      cmd_valid = 1; cmd_write = 1; cmd_addr = 6'h05; cmd_wdata = 32'h1234_5678;
      pready = 0;
      tick();
      cmd_valid = 0;
      exp_cmd_ready = 0; exp_psel = 1; exp_pen = 0;
      exp_pwrite = 1; exp_paddr = 6'h05; exp_pwdata = 32'h1234_5678;
      tick();
      exp_pen = 1;
      rstn = 0;
      tick();
      set_reset_exp();
      rstn = 1;
      for (int i = 0; i < 4; i++) tick();

      // randomized traffic
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 19) == 0) clear_cnt();
         xfer(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 6), ($urandom_range(0, 9) == 0),
              $urandom_range(0, 3), ($urandom_range(0, 19) == 0));
         if ($urandom_range(0, 3) == 0) tick();
      end
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
